// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the register-read hazard block
//
// Purpose: defines the in-flight slot record {wr, rd}, the pipeline depth
// and the hardwired zero register used by hazard_slot and regfileread_hazard.
package cpu_pkg;

  // One in-flight instruction: does it write the register file, and where.
  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } slot_t;

  localparam int          PIPE_DEPTH = 4;
  localparam logic [4:0]  ZERO_REG   = 5'd31;

  // Slots S1..S3 take part in the hazard check; S4 writes the register file
  // in the same cycle the decode stage reads it, so it never blocks a read.
  localparam logic [PIPE_DEPTH-1:0] HAZARD_MASK = 4'b0111;

endpackage

// File: rtl/hazard_slot.sv
// rtl/hazard_slot.sv - one in-flight pipeline slot with destination match
//
// Purpose: holds a single {wr, rd} record and reports whether it is a pending
// write to either of two probed source registers.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   d_i                   record entering the slot on the next edge
//   q_o                   record currently held
//   probe_a_i, probe_b_i  source register numbers to compare against
//   match_a_o, match_b_o  slot holds a pending write to the probed register
module hazard_slot
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  slot_t      d_i,
  output slot_t      q_o,
  input  logic [4:0] probe_a_i,
  input  logic [4:0] probe_b_i,
  output logic       match_a_o,
  output logic       match_b_o
);

  slot_t slot_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= d_i;
    end
  end

  assign q_o       = slot_q;
  assign match_a_o = slot_q.wr & (slot_q.rd == probe_a_i);
  assign match_b_o = slot_q.wr & (slot_q.rd == probe_b_i);

endmodule

// File: rtl/regfileread_hazard.sv
// rtl/regfileread_hazard.sv - decode-stage read-after-write stall generator
//
// Purpose: tracks four in-flight writes, stalls decode while a source register
// has a pending write in S1..S3, and counts stall cycles (saturating).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   IssueValid            decode presents an instruction
//   Rn/UseRn, Rm/UseRm    source registers and whether they are read
//   RegWrt, Rd            instruction writes register Rd
//   Stall                 presented instruction is held this cycle
//   WbRegWrt, WbRd        write-back enable / destination (slot S4)
//   StallCount            saturating count of stall cycles since reset
module regfileread_hazard
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       IssueValid,
  input  logic [4:0] Rn,
  input  logic       UseRn,
  input  logic [4:0] Rm,
  input  logic       UseRm,
  input  logic       RegWrt,
  input  logic [4:0] Rd,
  output logic       Stall,
  output logic       WbRegWrt,
  output logic [4:0] WbRd,
  output logic [7:0] StallCount
);

  // chain[0] is the incoming entry, chain[k] is slot Sk.
  slot_t                 chain [PIPE_DEPTH+1];
  logic [PIPE_DEPTH-1:0] rn_match;
  logic [PIPE_DEPTH-1:0] rm_match;
  logic                  hit_rn;
  logic                  hit_rm;
  logic                  accept;
  logic [7:0]            stall_cnt_q;
  logic [7:0]            stall_cnt_d;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_slot
    hazard_slot u_slot (
      .clk_i     (clk),
      .reset_i   (reset),
      .d_i       (chain[k]),
      .q_o       (chain[k+1]),
      .probe_a_i (Rn),
      .probe_b_i (Rm),
      .match_a_o (rn_match[k]),
      .match_b_o (rm_match[k])
    );
  end

  assign hit_rn = UseRn & (Rn != ZERO_REG) & (|(rn_match & HAZARD_MASK));
  assign hit_rm = UseRm & (Rm != ZERO_REG) & (|(rm_match & HAZARD_MASK));
  assign Stall  = IssueValid & (hit_rn | hit_rm);
  assign accept = IssueValid & ~Stall;

  // A stalled or absent instruction enters the pipe as a bubble, which is
  // what drains the blocking slot. Writes to the zero register never pend.
  always_comb begin
    chain[0] = '0;
    if (accept) begin
      chain[0].wr = RegWrt & (Rd != ZERO_REG);
      chain[0].rd = Rd;
    end
  end

  assign WbRegWrt = chain[PIPE_DEPTH].wr;
  assign WbRd     = chain[PIPE_DEPTH].rd;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_regfileread_hazard.sv
// tb/tb_regfileread_hazard.sv - scoreboard bench for regfileread_hazard
module tb_regfileread_hazard;

  logic       clk = 1'b0;
  logic       reset;
  logic       IssueValid;
  logic [4:0] Rn;
  logic       UseRn;
  logic [4:0] Rm;
  logic       UseRm;
  logic       RegWrt;
  logic [4:0] Rd;
  logic       Stall;
  logic       WbRegWrt;
  logic [4:0] WbRd;
  logic [7:0] StallCount;

  regfileread_hazard dut (
    .clk        (clk),
    .reset      (reset),
    .IssueValid (IssueValid),
    .Rn         (Rn),
    .UseRn      (UseRn),
    .Rm         (Rm),
    .UseRm      (UseRm),
    .RegWrt     (RegWrt),
    .Rd         (Rd),
    .Stall      (Stall),
    .WbRegWrt   (WbRegWrt),
    .WbRd       (WbRd),
    .StallCount (StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-back the DUT presents must match the oldest
  // expected entry, both in destination and in arrival cycle.
  always @(negedge clk) begin
    if (!reset && WbRegWrt) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_rd", int'(WbRd), int'(e.rd));
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called just after a posedge; drives one decode cycle and returns just
  // after the following posedge.
  task automatic step(input logic v, input logic [4:0] rn, input logic urn,
                      input logic [4:0] rm, input logic urm, input logic w,
                      input logic [4:0] rd, input logic exp_stall, input string name);
    exp_t e;
    IssueValid = v; Rn = rn; UseRn = urn; Rm = rm; UseRm = urm; RegWrt = w; Rd = rd;
    #1;
    check(name, int'(Stall), int'(exp_stall));
    if (v && !exp_stall && w && rd != 5'd31) begin
      e.rd  = rd;
      e.cyc = cyc + 4;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "idle_stall");
  endtask

  initial begin
    reset = 1'b1;
    IssueValid = 0; Rn = 0; UseRn = 0; Rm = 0; UseRm = 0; RegWrt = 0; Rd = 0;
    @(posedge clk); #1;
    check("rst_stall", int'(Stall), 0);
    check("rst_wbregwrt", int'(WbRegWrt), 0);
    check("rst_wbrd", int'(WbRd), 0);
    check("rst_stallcount", int'(StallCount), 0);
    reset = 1'b0;

    // Reset mid-stream: write to r5 sits in S2 when reset asserts.
    step(1, 0, 0, 0, 0, 1, 5, 0, "mid_wr5");
    step(1, 5, 1, 0, 0, 0, 0, 1, "mid_rd5_stall");
    IssueValid = 0;
    reset = 1'b1;
    #1;
    check("mid_rst_wbregwrt", int'(WbRegWrt), 0);
    check("mid_rst_stallcount", int'(StallCount), 0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, "post_rst_stall");
      check("post_rst_wbregwrt", int'(WbRegWrt), 0);
    end
    check("post_rst_stallcount", int'(StallCount), 0);

    // Single RAW hazard on r12: three stall cycles, accepted on the fourth.
    step(1, 0, 0, 0, 0, 1, 12, 0, "raw_wr12");
    step(1, 12, 1, 0, 0, 0, 0, 1, "raw_stall1");
    step(1, 12, 1, 0, 0, 0, 0, 1, "raw_stall2");
    step(1, 12, 1, 0, 0, 0, 0, 1, "raw_stall3");
    step(1, 12, 1, 0, 0, 0, 0, 0, "raw_accept");
    check("raw_stallcount", int'(StallCount), 3);

    // No stall without IssueValid, nor when the matching source is unused.
    step(1, 0, 0, 0, 0, 1, 20, 0, "nv_wr20");
    step(0, 20, 1, 20, 1, 0, 0, 0, "nv_novalid");
    step(1, 20, 0, 20, 0, 0, 0, 0, "nv_unused");

    // Zero register: never pending, never a hazard.
    step(1, 0, 0, 0, 0, 1, 31, 0, "zr_wr31");
    step(1, 31, 1, 31, 1, 0, 0, 0, "zr_rd31");
    idle(4);

    // Two sources hit different slots: stall until the younger write hits S4.
    step(1, 0, 0, 0, 0, 1, 3, 0, "two_wr3");
    step(1, 0, 0, 0, 0, 1, 7, 0, "two_wr7");
    step(1, 3, 1, 7, 1, 0, 0, 1, "two_stall1");
    step(1, 3, 1, 7, 1, 0, 0, 1, "two_stall2");
    step(1, 3, 1, 7, 1, 0, 0, 1, "two_stall3");
    step(1, 3, 1, 7, 1, 0, 0, 0, "two_accept");
    check("two_stallcount", int'(StallCount), 6);

    // Independent back-to-back writes: write-back on consecutive cycles.
    for (int i = 1; i <= 4; i++) step(1, 9, 1, 9, 1, 1, 5'(i), 0, "b2b_nostall");
    idle(5);

    // Self-dependent instruction re-issued: 3 stalls per accept, 303 in all.
    for (int i = 0; i < 101; i++) begin
      step(1, 5, 1, 0, 0, 1, 5, 0, "sat_accept");
      for (int j = 0; j < 3; j++) step(1, 5, 1, 0, 0, 1, 5, 1, "sat_stall");
    end
    check("sat_stallcount", int'(StallCount), 255);
    IssueValid = 0;
    idle(6);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
